sd_cmd_serial_host: RTL and testbench
=====================================

SD_CMD_SERIAL_HOST -- requirements
Module: sd_cmd_serial_host

Interface
REQ-001 SHALL have parameter RESP_TIMEOUT, default 255, meaning max cycles after the turnaround delay to wait for a response start bit.
REQ-002 SHALL have CLK_PAD_IO  in  1  sole clock, also the SD bit clock (one CMD bit per cycle).
REQ-003 SHALL have RST_PAD_I  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have settings  in  16  [10:8] turnaround delay, [7] CRC-check enable, [6:0] response size (0 none, 40 short, 127 long); other bits ignored.
REQ-005 SHALL have cmd_in  in  40  command frame to send (start, transmission, index, argument).
REQ-006 SHALL have req_in / ack_in  in  1 each  master request / master acknowledge.
REQ-007 SHALL have ack_out / req_out  out  1 each  ready-or-accept / status-valid.
REQ-008 SHALL have status  out  8  [6] data available, [5] CRC valid, [4] timeout, [3] end-bit error, others 0.
REQ-009 SHALL have cmd_out  out  40  first 40 bits of received response.
REQ-010 SHALL have cmd_dat_i in 1, cmd_out_o out 1, cmd_oe_o out 1: SD CMD line input, output, output enable.

Function
REQ-011 SHALL implement states IDLE, WRITE, DELAY, READ_WAIT, READ, REPORT.
REQ-012 IDLE: ack_out=1, req_out=0, cmd_oe_o=0; on req_in=1, latch cmd_in and settings, drop ack_out next cycle, go WRITE.
REQ-013 WRITE: cmd_oe_o=1 for exactly 48 cycles, MSB first: cmd_in[39:0], CRC7 (x^7+x^3+1, init 0) over those 40 bits, end bit 1.
REQ-014 After WRITE, size 0: go REPORT with status=8'h60.
REQ-015 DELAY: cmd_oe_o=0, cmd_out_o=1 for settings[10:8]+1 cycles, then READ_WAIT.
REQ-016 READ_WAIT: sample cmd_dat_i each cycle; first 0 is response bit 0, go READ; after RESP_TIMEOUT cycles with no 0, go REPORT with status=8'h50.
REQ-017 READ: receive 48 bits total (size 40) or 136 bits (size 127), start bit included; bits 0..39 shift into cmd_out MSB first.
REQ-018 Short CRC: CRC7 over bits 0..39 vs bits 40..46; long CRC: CRC7 over bits 8..127 vs bits 128..134; last bit SHALL be 1, else status[3]=1.
REQ-019 status[5]=1 when CRC matches or settings[7]=0; status[6]=1 on every REPORT entry.
REQ-020 REPORT: req_out=1 held until ack_in=1; then req_out=0 next cycle, return IDLE; status and cmd_out held stable until next req_in in IDLE.
REQ-021 req_in asserted outside IDLE SHALL be ignored; ack_in outside REPORT ignored.
REQ-022 req_in and ack_in arriving the same cycle in IDLE: req_in accepted, ack_in ignored.

Reset
REQ-023 On RST_PAD_I: state IDLE, req_out=0, ack_out=0, cmd_oe_o=0, cmd_out_o=1, status=0, cmd_out=0, all counters/CRC 0; ack_out rises first clock after release.
REQ-024 Reset mid-WRITE/READ SHALL release the line (cmd_oe_o=0) asynchronously, discarding partial frames.

Configuration
REQ-025 Macro SD_CMD_RESP_CRC_CHECK_EN: defined -> receive CRC7 logic present per REQ-018/019; undefined -> no receive CRC logic, status[5] always 1 on REPORT; transmit CRC always present.

Verification
REQ-026 cmd_in=40'h4000000000, size 0 -> line carries 48'h400000000095, then req_out=1, status=8'h60.
REQ-027 cmd_in=40'h48000001AA, size 40, delay 2, card returns 48'h08000001AA13 -> tx 48'h48000001AA87, cmd_out=40'h08000001AA, status=8'h60.
REQ-028 Same as 027 with response bit 20 flipped, settings[7]=1 -> status=8'h40 (8'h60 if macro undefined).
REQ-029 size 40, cmd_dat_i held 1 -> REPORT after exactly RESP_TIMEOUT cycles in READ_WAIT, status=8'h50.
REQ-030 RST_PAD_I pulse at WRITE bit 20 -> cmd_oe_o=0 immediately, ack_out=1 one clock after release, new command then sends correctly.

Source files
------------

// File: rtl/sd_cmd_serial_host_if.sv
// =====================================================================
// sd_cmd_serial_host_if : command/response handshake bus of the SD CMD host
// Rev 1.0
// =====================================================================
`default_nettype none

interface sd_cmd_serial_host_if;
  logic [15:0] settings;
  logic [39:0] cmd_in;
  logic        req_in;
  logic        ack_in;
  logic        ack_out;
  logic        req_out;
  logic [7:0]  status;
  logic [39:0] cmd_out;

  modport master (
    output settings, cmd_in, req_in, ack_in,
    input  ack_out, req_out, status, cmd_out
  );

  modport slave (
    input  settings, cmd_in, req_in, ack_in,
    output ack_out, req_out, status, cmd_out
  );
endinterface

`default_nettype wire

// File: rtl/sd_cmd_serial_host.sv
// =====================================================================
// sd_cmd_serial_host : SD CMD-line host, sends a 48-bit command and
// receives an optional 48/136-bit response. Receive CRC7 check is
// built only when SD_CMD_RESP_CRC_CHECK_EN is defined.
// Rev 1.0
// =====================================================================
`default_nettype none

module sd_cmd_serial_host #(
  parameter int RESP_TIMEOUT = 255
) (
  input  wire                  CLK_PAD_IO,
  input  wire                  RST_PAD_I,
  sd_cmd_serial_host_if.slave  host,
  input  wire                  cmd_dat_i,
  output logic                 cmd_out_o,
  output logic                 cmd_oe_o
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WRITE     = 3'd1;
  localparam logic [2:0] S_DELAY     = 3'd2;
  localparam logic [2:0] S_READ_WAIT = 3'd3;
  localparam logic [2:0] S_READ      = 3'd4;
  localparam logic [2:0] S_REPORT    = 3'd5;

  // One counter serves bit index, turnaround delay and response timeout.
  localparam int CNT_W = ($clog2(RESP_TIMEOUT + 1) > 8) ? $clog2(RESP_TIMEOUT + 1) : 8;
  localparam logic [CNT_W-1:0] TX_CRC_BIT = CNT_W'(40);
  localparam logic [CNT_W-1:0] TX_END_BIT = CNT_W'(47);
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(RESP_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [39:0]      tx_q, tx_d;
  logic [6:0]       crc_q, crc_d;
  logic [6:0]       size_q, size_d;
  logic [2:0]       dly_q, dly_d;
  logic [7:0]       status_q, status_d;
  logic [39:0]      cmd_out_q, cmd_out_d;
  logic             ack_out_q, ack_out_d;
  logic             req_out_q, req_out_d;

  logic             long_q;
  logic [7:0]       rx_idx;
  logic [7:0]       last_idx;
  logic [CNT_W-1:0] dly_ext;
  logic             rx_take;
  logic             crc_ok;

  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic b);
    logic fb;
    fb = b ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  assign long_q   = (size_q == 7'd127);
  assign last_idx = long_q ? 8'd135 : 8'd47;
  assign rx_idx   = (state_q == S_READ) ? cnt_q[7:0] : 8'd0;
  assign dly_ext  = {{(CNT_W-3){1'b0}}, dly_q};

`ifdef SD_CMD_RESP_CRC_CHECK_EN
  logic       crc_en_q, crc_en_d;
  logic       mismatch_q, mismatch_d;
  logic [7:0] crc_lo;
  logic [7:0] crc_hi;
  logic       unused_settings;

  // Long responses exclude the 8-bit header from the CRC.
  assign crc_lo          = long_q ? 8'd8   : 8'd0;
  assign crc_hi          = long_q ? 8'd128 : 8'd40;
  assign crc_ok          = ~crc_en_q | ~mismatch_q;
  assign unused_settings = ^host.settings[15:11];
`else
  logic unused_settings;

  assign crc_ok          = 1'b1;
  assign unused_settings = ^{host.settings[15:11], host.settings[7]};
`endif

  always_ff @(posedge CLK_PAD_IO or posedge RST_PAD_I) begin
    if (RST_PAD_I) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (host.req_in) state_d = S_WRITE;
      S_WRITE:     if (cnt_q == TX_END_BIT) state_d = (size_q == 7'd0) ? S_REPORT : S_DELAY;
      S_DELAY:     if (cnt_q == dly_ext) state_d = S_READ_WAIT;
      S_READ_WAIT: begin
        if (!cmd_dat_i)             state_d = S_READ;
        else if (cnt_q == TO_LAST)  state_d = S_REPORT;
      end
      S_READ:      if (rx_idx == last_idx) state_d = S_REPORT;
      S_REPORT:    if (host.ack_in) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ack_out_d = (state_d == S_IDLE);
    req_out_d = (state_d == S_REPORT);
    cmd_oe_o  = (state_q == S_WRITE);
    cmd_out_o = 1'b1;
    if (state_q == S_WRITE) begin
      if (cnt_q < TX_CRC_BIT)      cmd_out_o = tx_q[39];
      else if (cnt_q < TX_END_BIT) cmd_out_o = crc_q[6];
    end
  end

  always_comb begin
    tx_d      = tx_q;
    crc_d     = crc_q;
    cnt_d     = cnt_q;
    size_d    = size_q;
    dly_d     = dly_q;
    status_d  = status_q;
    cmd_out_d = cmd_out_q;
    rx_take   = 1'b0;
`ifdef SD_CMD_RESP_CRC_CHECK_EN
    crc_en_d   = crc_en_q;
    mismatch_d = mismatch_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (host.req_in) begin
          tx_d      = host.cmd_in;
          size_d    = host.settings[6:0];
          dly_d     = host.settings[10:8];
          crc_d     = '0;
          cnt_d     = '0;
          status_d  = '0;
          cmd_out_d = '0;
`ifdef SD_CMD_RESP_CRC_CHECK_EN
          crc_en_d   = host.settings[7];
          mismatch_d = 1'b0;
`endif
        end
      end
      S_WRITE: begin
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q < TX_CRC_BIT) begin
          crc_d = crc7_step(crc_q, tx_q[39]);
          tx_d  = {tx_q[38:0], 1'b0};
        end else begin
          crc_d = {crc_q[5:0], 1'b0};
        end
        if (cnt_q == TX_END_BIT) begin
          cnt_d = '0;
          crc_d = '0;
          if (size_q == 7'd0) status_d = 8'h60;
        end
      end
      S_DELAY: begin
        cnt_d = (cnt_q == dly_ext) ? '0 : cnt_q + CNT_ONE;
      end
      S_READ_WAIT: begin
        cnt_d = cnt_q + CNT_ONE;
        if (!cmd_dat_i) begin
          rx_take = 1'b1;
          cnt_d   = CNT_ONE;
        end else if (cnt_q == TO_LAST) begin
          cnt_d    = '0;
          status_d = 8'h50;
        end
      end
      S_READ: begin
        rx_take = 1'b1;
        cnt_d   = cnt_q + CNT_ONE;
      end
      default: ;
    endcase

    // The start bit is consumed in READ_WAIT as bit 0, the rest in READ.
    if (rx_take) begin
      if (rx_idx < 8'd40) cmd_out_d = {cmd_out_q[38:0], cmd_dat_i};
`ifdef SD_CMD_RESP_CRC_CHECK_EN
      if (rx_idx >= crc_lo && rx_idx < crc_hi) begin
        crc_d = crc7_step(crc_q, cmd_dat_i);
      end else if (rx_idx >= crc_hi && rx_idx < crc_hi + 8'd7) begin
        mismatch_d = mismatch_q | (cmd_dat_i ^ crc_q[6]);
        crc_d      = {crc_q[5:0], 1'b0};
      end
`endif
      if (rx_idx == last_idx) begin
        cnt_d    = '0;
        status_d = {1'b0, 1'b1, crc_ok, 1'b0, ~cmd_dat_i, 3'b000};
      end
    end
  end

  always_ff @(posedge CLK_PAD_IO or posedge RST_PAD_I) begin
    if (RST_PAD_I) begin
      cnt_q     <= '0;
      tx_q      <= '0;
      crc_q     <= '0;
      size_q    <= '0;
      dly_q     <= '0;
      status_q  <= '0;
      cmd_out_q <= '0;
      ack_out_q <= 1'b0;
      req_out_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      tx_q      <= tx_d;
      crc_q     <= crc_d;
      size_q    <= size_d;
      dly_q     <= dly_d;
      status_q  <= status_d;
      cmd_out_q <= cmd_out_d;
      ack_out_q <= ack_out_d;
      req_out_q <= req_out_d;
    end
  end

`ifdef SD_CMD_RESP_CRC_CHECK_EN
  always_ff @(posedge CLK_PAD_IO or posedge RST_PAD_I) begin
    if (RST_PAD_I) begin
      crc_en_q   <= 1'b0;
      mismatch_q <= 1'b0;
    end else begin
      crc_en_q   <= crc_en_d;
      mismatch_q <= mismatch_d;
    end
  end
`endif

  assign host.ack_out = ack_out_q;
  assign host.req_out = req_out_q;
  assign host.status  = status_q;
  assign host.cmd_out = cmd_out_q;

endmodule

`default_nettype wire

// File: tb/tb_sd_cmd_serial_host.sv
// =====================================================================
// tb_sd_cmd_serial_host : directed self-checking bench for sd_cmd_serial_host
// Rev 1.0
// =====================================================================
`default_nettype none

module tb_sd_cmd_serial_host;
  localparam int TO = 255;
`ifdef SD_CMD_RESP_CRC_CHECK_EN
  localparam logic [7:0] BAD_CRC_STATUS = 8'h40;
`else
  localparam logic [7:0] BAD_CRC_STATUS = 8'h60;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmd_dat_i = 1'b1;
  logic cmd_out_o;
  logic cmd_oe_o;
  int   errors = 0;
  int   checks = 0;

  sd_cmd_serial_host_if bus ();

  sd_cmd_serial_host #(.RESP_TIMEOUT(TO)) dut (
    .CLK_PAD_IO (clk),
    .RST_PAD_I  (rst),
    .host       (bus),
    .cmd_dat_i  (cmd_dat_i),
    .cmd_out_o  (cmd_out_o),
    .cmd_oe_o   (cmd_oe_o)
  );

  always #5 clk = ~clk;

  // Reference CRC7 (x^7+x^3+1) over bits lo..hi-1 of an MSB-first 136-bit frame
  function automatic logic [6:0] crc7(input logic [135:0] v, input int lo, input int hi);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = lo; i < hi; i++) begin
      fb = v[135-i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  task automatic send_frame(input logic [39:0] cmd, input logic [15:0] set, input logic with_ack,
                            input int glitch_at, output logic [47:0] tx, output int oe_bad);
    bus.cmd_in   = cmd;
    bus.settings = set;
    bus.req_in   = 1'b1;
    bus.ack_in   = with_ack;
    @(negedge clk);
    bus.req_in = 1'b0;
    bus.ack_in = 1'b0;
    tx     = '0;
    oe_bad = 0;
    for (int i = 0; i < 48; i++) begin
      if (cmd_oe_o !== 1'b1) oe_bad++;
      tx = {tx[46:0], cmd_out_o};
      if (i == glitch_at) begin
        bus.req_in   = 1'b1;
        bus.cmd_in   = 40'hFF_FFFF_FFFF;
        bus.settings = 16'h07FF;
      end else begin
        bus.req_in = 1'b0;
      end
      @(negedge clk);
    end
    bus.req_in = 1'b0;
    if (cmd_oe_o !== 1'b0) oe_bad++;
  endtask

  // Drives 0 during the turnaround (must be ignored), then the response bits.
  task automatic drive_resp(input logic [135:0] r, input int nbits, input int dly, output int line_bad);
    line_bad = 0;
    for (int d = 0; d <= dly; d++) begin
      if (cmd_oe_o !== 1'b0 || cmd_out_o !== 1'b1) line_bad++;
      cmd_dat_i = 1'b0;
      @(negedge clk);
    end
    for (int i = 0; i < nbits; i++) begin
      cmd_dat_i = r[135-i];
      @(negedge clk);
    end
    cmd_dat_i = 1'b1;
  endtask

  task automatic pulse_ack();
    bus.ack_in = 1'b1;
    @(negedge clk);
    bus.ack_in = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    checks++; if (bus.req_out !== 1'b0) begin errors++; $display("FAIL rst_req_out: got %b want 0", bus.req_out); end
    checks++; if (bus.ack_out !== 1'b0) begin errors++; $display("FAIL rst_ack_out: got %b want 0", bus.ack_out); end
    checks++; if (cmd_oe_o !== 1'b0) begin errors++; $display("FAIL rst_oe: got %b want 0", cmd_oe_o); end
    checks++; if (cmd_out_o !== 1'b1) begin errors++; $display("FAIL rst_line: got %b want 1", cmd_out_o); end
    checks++; if (bus.status !== 8'h00) begin errors++; $display("FAIL rst_status: got %h want 00", bus.status); end
    checks++; if (bus.cmd_out !== 40'h0) begin errors++; $display("FAIL rst_cmd_out: got %h want 0", bus.cmd_out); end
    rst = 1'b0;
    #1;
    checks++; if (bus.ack_out !== 1'b0) begin errors++; $display("FAIL rst_release_ack: got %b want 0", bus.ack_out); end
    @(negedge clk);
    checks++; if (bus.ack_out !== 1'b1) begin errors++; $display("FAIL rst_first_clk_ack: got %b want 1", bus.ack_out); end
  endtask

  task automatic test_no_resp();
    logic [47:0] tx;
    int          ob;
    send_frame(40'h40_0000_0000, 16'h0000, 1'b0, -1, tx, ob);
    checks++; if (tx !== 48'h4000_0000_0095) begin errors++; $display("FAIL cmd0_tx: got %h want 400000000095", tx); end
    checks++; if (ob !== 0) begin errors++; $display("FAIL cmd0_oe: got %0d bad cycles want 0", ob); end
    checks++; if (bus.req_out !== 1'b1) begin errors++; $display("FAIL cmd0_req_out: got %b want 1", bus.req_out); end
    checks++; if (bus.status !== 8'h60) begin errors++; $display("FAIL cmd0_status: got %h want 60", bus.status); end
    checks++; if (bus.ack_out !== 1'b0) begin errors++; $display("FAIL cmd0_ack_out: got %b want 0", bus.ack_out); end
    @(negedge clk);
    checks++; if (bus.req_out !== 1'b1) begin errors++; $display("FAIL cmd0_req_hold: got %b want 1", bus.req_out); end
    pulse_ack();
    checks++; if (bus.req_out !== 1'b0 || bus.ack_out !== 1'b1) begin errors++; $display("FAIL cmd0_ack_done: got req=%b ack=%b want req=0 ack=1", bus.req_out, bus.ack_out); end
    checks++; if (bus.status !== 8'h60) begin errors++; $display("FAIL cmd0_status_hold: got %h want 60", bus.status); end
  endtask

  task automatic test_short_resp();
    logic [47:0] tx;
    int          ob;
    int          lb;
    send_frame(40'h48_0000_01AA, 16'h02A8, 1'b0, -1, tx, ob);
    checks++; if (tx !== 48'h4800_0001_AA87) begin errors++; $display("FAIL cmd8_tx: got %h want 48000001AA87", tx); end
    drive_resp({48'h0800_0001_AA13, 88'h0}, 48, 2, lb);
    checks++; if (lb !== 0) begin errors++; $display("FAIL cmd8_turnaround: got %0d bad cycles want 0", lb); end
    checks++; if (bus.req_out !== 1'b1) begin errors++; $display("FAIL cmd8_req_out: got %b want 1", bus.req_out); end
    checks++; if (bus.cmd_out !== 40'h08_0000_01AA) begin errors++; $display("FAIL cmd8_cmd_out: got %h want 08000001AA", bus.cmd_out); end
    checks++; if (bus.status !== 8'h60) begin errors++; $display("FAIL cmd8_status: got %h want 60", bus.status); end
    pulse_ack();
    checks++; if (bus.ack_out !== 1'b1) begin errors++; $display("FAIL cmd8_ack_out: got %b want 1", bus.ack_out); end
  endtask

  task automatic test_crc_error();
    logic [47:0] tx;
    logic [47:0] r48;
    int          ob;
    int          lb;
    r48 = 48'h0800_0001_AA13 ^ 48'h0000_0800_0000;
    send_frame(40'h48_0000_01AA, 16'h02A8, 1'b0, -1, tx, ob);
    drive_resp({r48, 88'h0}, 48, 2, lb);
    checks++; if (bus.status !== BAD_CRC_STATUS) begin errors++; $display("FAIL crcerr_status: got %h want %h", bus.status, BAD_CRC_STATUS); end
    checks++; if (bus.cmd_out !== 40'h08_0008_01AA) begin errors++; $display("FAIL crcerr_cmd_out: got %h want 08000801AA", bus.cmd_out); end
    pulse_ack();
    send_frame(40'h48_0000_01AA, 16'h0228, 1'b0, -1, tx, ob);
    drive_resp({r48, 88'h0}, 48, 2, lb);
    checks++; if (bus.status !== 8'h60) begin errors++; $display("FAIL crcoff_status: got %h want 60", bus.status); end
    pulse_ack();
  endtask

  task automatic test_end_bit();
    logic [47:0] tx;
    int          ob;
    int          lb;
    send_frame(40'h48_0000_01AA, 16'h01A8, 1'b0, -1, tx, ob);
    drive_resp({48'h0800_0001_AA12, 88'h0}, 48, 1, lb);
    checks++; if (bus.status !== 8'h68) begin errors++; $display("FAIL endbit_status: got %h want 68", bus.status); end
    checks++; if (lb !== 0) begin errors++; $display("FAIL endbit_turnaround: got %0d bad cycles want 0", lb); end
    pulse_ack();
  endtask

  task automatic test_long_resp();
    logic [47:0]  tx;
    logic [47:0]  exp_tx;
    logic [39:0]  cmd;
    logic [135:0] r;
    int           ob;
    int           lb;
    cmd    = 40'h42_0000_0000;
    exp_tx = {cmd, crc7({cmd, 96'h0}, 0, 40), 1'b1};
    r      = {8'h3F, 120'h0353_4453_5344_3038_4780_1234_5678_AB, 7'h00, 1'b1};
    r[7:1] = crc7(r, 8, 128);
    send_frame(cmd, 16'h00FF, 1'b0, -1, tx, ob);
    checks++; if (tx !== exp_tx) begin errors++; $display("FAIL cmd2_tx: got %h want %h", tx, exp_tx); end
    drive_resp(r, 136, 0, lb);
    checks++; if (bus.req_out !== 1'b1) begin errors++; $display("FAIL long_req_out: got %b want 1", bus.req_out); end
    checks++; if (bus.cmd_out !== r[135:96]) begin errors++; $display("FAIL long_cmd_out: got %h want %h", bus.cmd_out, r[135:96]); end
    checks++; if (bus.status !== 8'h60) begin errors++; $display("FAIL long_status: got %h want 60", bus.status); end
    pulse_ack();
  endtask

  task automatic test_timeout();
    logic [47:0] tx;
    int          ob;
    int          n;
    send_frame(40'h48_0000_01AA, 16'h0028, 1'b0, -1, tx, ob);
    cmd_dat_i = 1'b1;
    n = 0;
    while (bus.req_out !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checks++; if (n !== TO + 1) begin errors++; $display("FAIL timeout_cycles: got %0d want %0d", n, TO + 1); end
    checks++; if (bus.status !== 8'h50) begin errors++; $display("FAIL timeout_status: got %h want 50", bus.status); end
    checks++; if (bus.cmd_out !== 40'h0) begin errors++; $display("FAIL timeout_cmd_out: got %h want 0", bus.cmd_out); end
    pulse_ack();
  endtask

  task automatic test_reset_mid_write();
    logic [47:0] tx;
    int          ob;
    bus.cmd_in   = 40'h48_0000_01AA;
    bus.settings = 16'h0028;
    bus.req_in   = 1'b1;
    @(negedge clk);
    bus.req_in = 1'b0;
    repeat (20) @(negedge clk);
    checks++; if (cmd_oe_o !== 1'b1) begin errors++; $display("FAIL midrst_pre_oe: got %b want 1", cmd_oe_o); end
    #2 rst = 1'b1;
    #1;
    checks++; if (cmd_oe_o !== 1'b0 || cmd_out_o !== 1'b1) begin errors++; $display("FAIL midrst_release: got oe=%b line=%b want oe=0 line=1", cmd_oe_o, cmd_out_o); end
    checks++; if (bus.ack_out !== 1'b0) begin errors++; $display("FAIL midrst_ack: got %b want 0", bus.ack_out); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.ack_out !== 1'b1) begin errors++; $display("FAIL midrst_ack_rise: got %b want 1", bus.ack_out); end
    send_frame(40'h40_0000_0000, 16'h0000, 1'b0, -1, tx, ob);
    checks++; if (tx !== 48'h4000_0000_0095) begin errors++; $display("FAIL midrst_tx: got %h want 400000000095", tx); end
    checks++; if (bus.status !== 8'h60) begin errors++; $display("FAIL midrst_status: got %h want 60", bus.status); end
    pulse_ack();
  endtask

  task automatic test_back_to_back();
    logic [47:0] tx;
    logic [47:0] exp_tx;
    logic [39:0] cmd;
    int          ob;
    pulse_ack();
    checks++; if (bus.ack_out !== 1'b1 || cmd_oe_o !== 1'b0) begin errors++; $display("FAIL idle_ack_ignored: got ack_out=%b oe=%b want 1/0", bus.ack_out, cmd_oe_o); end
    send_frame(40'h40_0000_0000, 16'h0000, 1'b0, 10, tx, ob);
    checks++; if (tx !== 48'h4000_0000_0095) begin errors++; $display("FAIL glitch_tx: got %h want 400000000095", tx); end
    checks++; if (bus.req_out !== 1'b1) begin errors++; $display("FAIL glitch_req_out: got %b want 1", bus.req_out); end
    pulse_ack();
    checks++; if (bus.ack_out !== 1'b1 || cmd_oe_o !== 1'b0) begin errors++; $display("FAIL glitch_no_retrigger: got ack_out=%b oe=%b want 1/0", bus.ack_out, cmd_oe_o); end
    cmd    = 40'h77_0000_0000;
    exp_tx = {cmd, crc7({cmd, 96'h0}, 0, 40), 1'b1};
    send_frame(cmd, 16'h0000, 1'b1, -1, tx, ob);
    checks++; if (tx !== exp_tx) begin errors++; $display("FAIL b2b_tx: got %h want %h", tx, exp_tx); end
    checks++; if (ob !== 0) begin errors++; $display("FAIL b2b_oe: got %0d bad cycles want 0", ob); end
    @(negedge clk);
    checks++; if (bus.req_out !== 1'b1) begin errors++; $display("FAIL b2b_req_hold: got %b want 1", bus.req_out); end
    pulse_ack();
    checks++; if (bus.req_out !== 1'b0 || bus.ack_out !== 1'b1) begin errors++; $display("FAIL b2b_done: got req=%b ack=%b want 0/1", bus.req_out, bus.ack_out); end
  endtask

  initial begin
    bus.settings = '0;
    bus.cmd_in   = '0;
    bus.req_in   = 1'b0;
    bus.ack_in   = 1'b0;
    test_reset();
    test_no_resp();
    test_short_resp();
    test_crc_error();
    test_end_bit();
    test_long_resp();
    test_timeout();
    test_reset_mid_write();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
